// File: rtl/ascii_hex_parser.sv
// ASCII hex token parser: folds hex digit strings into binary words, one word per
// terminated token, with error pulses for illegal characters and over-long tokens.
module ascii_hex_parser #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [4:0]            digit_count,
  output logic                  err_invalid,
  output logic                  err_overflow
);

  localparam int unsigned MaxDigits = DATA_WIDTH / 4;

  typedef enum logic [1:0] {StIdle, StAccum, StHold, StDiscard} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [4:0]            count_q, count_d;
  logic [4:0]            dcount_q, dcount_d;
  logic                  err_inv_q, err_inv_d;
  logic                  err_ovf_q, err_ovf_d;

  logic       accept;
  logic       is_digit;
  logic       is_term;
  logic       is_invalid;
  logic       at_max;
  logic [3:0] nibble;

  // Character classification and digit value.
  always_comb begin
    is_digit = 1'b1;
    is_term  = 1'b0;
    nibble   = 4'd0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nibble = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      nibble = rx_data[3:0] + 4'd9;
    end else begin
      is_digit = 1'b0;
      is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h20);
    end
  end

  assign is_invalid = !is_digit && !is_term;
  assign accept     = rx_valid && rx_ready;
  assign at_max     = (count_q == 5'(MaxDigits));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_digit) begin
          state_d = StAccum;
        end else if (accept && is_invalid) begin
          state_d = StDiscard;
        end
      end
      StAccum: begin
        if (accept && is_term) begin
          state_d = StHold;
        end else if (accept && (is_invalid || at_max)) begin
          state_d = StDiscard;
        end
      end
      StHold: begin
        if (word_ready) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (accept && is_term) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Both handshake outputs come straight from the registered state.
  always_comb begin
    rx_ready     = (state_q != StHold);
    word_valid   = (state_q == StHold);
    word_out     = word_q;
    digit_count  = dcount_q;
    err_invalid  = err_inv_q;
    err_overflow = err_ovf_q;
  end

  always_comb begin
    acc_d     = acc_q;
    count_d   = count_q;
    word_d    = word_q;
    dcount_d  = dcount_q;
    err_inv_d = 1'b0;
    err_ovf_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && is_digit) begin
          acc_d   = DATA_WIDTH'(nibble);
          count_d = 5'd1;
        end else if (accept && is_invalid) begin
          err_inv_d = 1'b1;
        end
      end
      StAccum: begin
        if (accept && is_digit) begin
          if (at_max) begin
            err_ovf_d = 1'b1;
          end else begin
            acc_d   = (acc_q << 4) | DATA_WIDTH'(nibble);
            count_d = count_q + 5'd1;
          end
        end else if (accept && is_invalid) begin
          err_inv_d = 1'b1;
        end else if (accept && is_term) begin
          word_d   = acc_q;
          dcount_d = count_q;
        end
      end
      StHold: begin
        if (word_ready) begin
          acc_d   = '0;
          count_d = 5'd0;
        end
      end
      StDiscard: begin
        if (accept && is_term) begin
          acc_d   = '0;
          count_d = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      count_q   <= 5'd0;
      word_q    <= '0;
      dcount_q  <= 5'd0;
      err_inv_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      count_q   <= count_d;
      word_q    <= word_d;
      dcount_q  <= dcount_d;
      err_inv_q <= err_inv_d;
      err_ovf_q <= err_ovf_d;
    end
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: directed vector table, multi-cycle corner sequences and
// random streams checked against a token-level reference model.
module tb_ascii_hex_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [4:0]  digit_count;
  logic        err_invalid;
  logic        err_overflow;

  ascii_hex_parser #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .digit_count  (digit_count),
    .err_invalid  (err_invalid),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Observed traffic.
  logic [31:0] got_w[$];
  int          got_dc[$];
  int          n_inv = 0;
  int          n_ovf = 0;
  bit          mon_on = 1'b0;
  bit          rnd_ready = 1'b0;
  logic        p_v = 1'b0, p_r = 1'b0, p_rst = 1'b0;
  logic [31:0] p_w = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (word_valid && word_ready) begin
        got_w.push_back(word_out);
        got_dc.push_back(int'(digit_count));
      end
      if (err_invalid) n_inv++;
      if (err_overflow) n_ovf++;
      chk("rx_ready_vs_hold", {63'd0, rx_ready}, {63'd0, !word_valid});
      if (p_v && !p_r && p_rst) begin
        chk("hold_valid", {63'd0, word_valid}, 64'd1);
        chk("hold_word", {32'd0, word_out}, {32'd0, p_w});
      end
    end
    p_v = word_valid;
    p_r = word_ready;
    p_w = word_out;
    p_rst = rst_n;
  end

  task automatic clear_mon();
    got_w.delete();
    got_dc.delete();
    n_inv = 0;
    n_ovf = 0;
  endtask

  task automatic send_byte(input byte b);
    bit taken;
    int tries;
    taken = 1'b0;
    tries = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!taken && tries < 200) begin
      if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      taken = rx_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    rx_valid = 1'b0;
    if (!taken) begin
      bad++;
      total++;
      $display("FAIL byte_accept_timeout: got=not_accepted expected=accepted");
    end
  endtask

  task automatic send_q(input byte q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  function automatic void str2q(input string s, output byte q[$]);
    q.delete();
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
  endfunction

  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (rnd_ready) word_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: split on terminators, judge each token as a whole.
  logic [31:0] exp_w[$];
  int          exp_dc[$];
  int          e_inv, e_ovf;

  function automatic int hexval(input byte c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c == 8'h0D || c == 8'h0A || c == 8'h20) return -2;
    return -1;
  endfunction

  function automatic void model(input byte q[$]);
    longint val;
    int cnt;
    bit dead;
    int v;
    exp_w.delete();
    exp_dc.delete();
    e_inv = 0;
    e_ovf = 0;
    val = 0;
    cnt = 0;
    dead = 1'b0;
    foreach (q[i]) begin
      v = hexval(q[i]);
      if (v == -2) begin
        if (!dead && cnt > 0) begin
          exp_w.push_back(32'(val));
          exp_dc.push_back(cnt);
        end
        val = 0;
        cnt = 0;
        dead = 1'b0;
      end else if (dead) begin
      end else if (v == -1) begin
        e_inv++;
        dead = 1'b1;
      end else if (cnt == 8) begin
        e_ovf++;
        dead = 1'b1;
      end else begin
        val = val * 16 + v;
        cnt++;
      end
    end
  endfunction

  typedef struct {
    string       s;
    int          n_words;
    logic [31:0] last;
    int          dc;
    int          inv;
    int          ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string s, input int n, input logic [31:0] last, input int dc,
                         input int inv, input int ovf);
    vec_t v;
    v.s = s;
    v.n_words = n;
    v.last = last;
    v.dc = dc;
    v.inv = inv;
    v.ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    byte q[$];
    byte digs[$];
    byte bads[$];
    int n;
    int r;

    add_vec("1A2b\015",            1, 32'h00001A2B, 4, 0, 0);
    add_vec("\015\012  \015\012",  0, 32'h0,        0, 0, 0);
    add_vec("7\015\012",           1, 32'h7,        1, 0, 0);
    add_vec("12G4 55\015",         1, 32'h55,       2, 1, 0);
    add_vec("123456789 A\015",     1, 32'hA,        1, 0, 1);
    add_vec("FFFFFFFF\015",        1, 32'hFFFFFFFF, 8, 0, 0);
    add_vec("0x1F\015",            0, 32'h0,        0, 1, 0);
    add_vec("00000000A\015",       0, 32'h0,        0, 0, 1);
    add_vec("ab cd\015",           2, 32'hCD,       2, 0, 0);
    add_vec("Q\0153\015",          1, 32'h3,        1, 1, 0);
    add_vec("g99999999999 1\015",  1, 32'h1,        1, 1, 0);
    add_vec("00c0ffee\012",        1, 32'h00C0FFEE, 8, 0, 0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_word_out", {32'd0, word_out}, 64'd0);
    chk("rst_digit_count", {59'd0, digit_count}, 64'd0);
    chk("rst_err_invalid", {63'd0, err_invalid}, 64'd0);
    chk("rst_err_overflow", {63'd0, err_overflow}, 64'd0);
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table.
    foreach (vecs[i]) begin
      clear_mon();
      str2q(vecs[i].s, q);
      send_q(q);
      drain();
      chk($sformatf("vec%0d_words", i), 64'(got_w.size()), 64'(vecs[i].n_words));
      if (got_w.size() > 0 && vecs[i].n_words > 0) begin
        chk($sformatf("vec%0d_last", i), {32'd0, got_w[$]}, {32'd0, vecs[i].last});
        chk($sformatf("vec%0d_dc", i), 64'(got_dc[$]), 64'(vecs[i].dc));
      end
      chk($sformatf("vec%0d_inv", i), 64'(n_inv), 64'(vecs[i].inv));
      chk($sformatf("vec%0d_ovf", i), 64'(n_ovf), 64'(vecs[i].ovf));
    end

    // Back-pressure: word held for 5 cycles, bytes offered meanwhile are not taken.
    clear_mon();
    word_ready = 1'b0;
    str2q("DEADBEEF\012", q);
    send_q(q);
    for (int k = 0; k < 5; k++) begin
      rx_data = "5";
      rx_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", {63'd0, word_valid}, 64'd1);
      chk("bp_word", {32'd0, word_out}, 64'hDEADBEEF);
      chk("bp_dc", {59'd0, digit_count}, 64'd8);
      chk("bp_rx_ready", {63'd0, rx_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_valid", {63'd0, word_valid}, 64'd0);
    chk("bp_release_rx_ready", {63'd0, rx_ready}, 64'd1);
    @(posedge clk);
    #1;
    chk("bp_words", 64'(got_w.size()), 64'd1);
    chk("bp_err_none", 64'(n_inv + n_ovf), 64'd0);

    // Error pulse timing: high exactly one cycle after the offending byte.
    clear_mon();
    str2q("12G", q);
    send_q(q);
    @(negedge clk);
    chk("inv_pulse_hi", {63'd0, err_invalid}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("inv_pulse_lo", {63'd0, err_invalid}, 64'd0);
    @(posedge clk);
    #1;
    str2q("4 123456789", q);
    send_q(q);
    @(negedge clk);
    chk("ovf_pulse_hi", {63'd0, err_overflow}, 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("ovf_pulse_lo", {63'd0, err_overflow}, 64'd0);
    @(posedge clk);
    #1;
    str2q("\015", q);
    send_q(q);
    drain();
    chk("pulse_words", 64'(got_w.size()), 64'd0);
    chk("pulse_inv_cnt", 64'(n_inv), 64'd1);
    chk("pulse_ovf_cnt", 64'(n_ovf), 64'd1);

    // Reset mid-token drops the partial value.
    clear_mon();
    str2q("AB", q);
    send_q(q);
    pulse_reset();
    str2q("C\015", q);
    send_q(q);
    drain();
    chk("midrst_words", 64'(got_w.size()), 64'd1);
    if (got_w.size() > 0) chk("midrst_word", {32'd0, got_w[0]}, 64'hC);

    // Reset during HOLD loses the pending word.
    clear_mon();
    word_ready = 1'b0;
    str2q("5\015", q);
    send_q(q);
    @(negedge clk);
    chk("holdrst_pre_valid", {63'd0, word_valid}, 64'd1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    chk("holdrst_valid", {63'd0, word_valid}, 64'd0);
    chk("holdrst_rx_ready", {63'd0, rx_ready}, 64'd1);
    word_ready = 1'b1;
    drain();
    chk("holdrst_words", 64'(got_w.size()), 64'd0);

    // Random streams with random back-pressure.
    str2q("0123456789abcdefABCDEF", digs);
    str2q("xGzq.-#", bads);
    rnd_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      q.delete();
      n = $urandom_range(1, 30);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 99);
        if (r < 70) q.push_back(digs[$urandom_range(0, digs.size() - 1)]);
        else if (r < 77) q.push_back(8'h0D);
        else if (r < 84) q.push_back(8'h0A);
        else if (r < 92) q.push_back(8'h20);
        else q.push_back(bads[$urandom_range(0, bads.size() - 1)]);
      end
      q.push_back(8'h0D);
      model(q);
      clear_mon();
      send_q(q);
      drain();
      chk($sformatf("rnd%0d_words", it), 64'(got_w.size()), 64'(exp_w.size()));
      for (int j = 0; j < got_w.size() && j < exp_w.size(); j++) begin
        chk($sformatf("rnd%0d_w%0d", it, j), {32'd0, got_w[j]}, {32'd0, exp_w[j]});
        chk($sformatf("rnd%0d_dc%0d", it, j), 64'(got_dc[j]), 64'(exp_dc[j]));
      end
      chk($sformatf("rnd%0d_inv", it), 64'(n_inv), 64'(e_inv));
      chk($sformatf("rnd%0d_ovf", it), 64'(n_ovf), 64'(e_ovf));
    end
    rnd_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser.md
# ascii_hex_parser

Receives a byte stream of ASCII characters, typically from the UART receive path, and assembles hexadecimal digit strings into binary words. It performs the inverse of the nibble-to-ASCII conversion used on the transmit/display side. Each terminated token produces one word on a valid/ready output. Malformed or over-long tokens are flagged and dropped.

## Interface
- DATA_WIDTH, 32: output word width; multiple of 4, range 4..64; MAX_DIGITS = DATA_WIDTH/4
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- rx_data  in  8  incoming ASCII character
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  parser can accept a character this cycle
- word_out  out  DATA_WIDTH  parsed value, right-aligned, zero-extended
- word_valid  out  1  word_out valid; held until accepted
- word_ready  in  1  downstream accepts word_out
- digit_count  out  5  number of digits in the current/last emitted token
- err_invalid  out  1  one-cycle pulse: illegal character inside a token
- err_overflow  out  1  one-cycle pulse: token exceeds MAX_DIGITS

## Operation
- Character accepted when rx_valid && rx_ready; otherwise ignored.
- Classes: digit = 0x30-0x39 (0-9), 0x41-0x46 (A-F), 0x61-0x66 (a-f); terminator = 0x0D, 0x0A, 0x20; everything else is invalid (including 'x', so a "0x" prefix is an error).
- Digit value: 0-9 -> 0..9; A-F/a-f -> 10..15.
- States: IDLE, ACCUM, HOLD, DISCARD.
- IDLE: digit -> acc = nibble, count = 1, go ACCUM; terminator -> ignored, stay (CRLF and repeated spaces produce no words); invalid -> err_invalid pulse, go DISCARD.
- ACCUM: digit with count < MAX_DIGITS -> acc = {acc[DATA_WIDTH-5:0], nibble}, count+1; digit with count == MAX_DIGITS -> err_overflow pulse, go DISCARD; invalid -> err_invalid pulse, go DISCARD; terminator -> word_out = acc, digit_count = count, word_valid = 1, go HOLD.
- HOLD: rx_ready = 0; word_out and digit_count stable; on word_valid && word_ready -> word_valid = 0, acc and count cleared, go IDLE.
- DISCARD: digits and invalid characters are consumed silently (no further error pulses); terminator -> clear acc/count, go IDLE; no word emitted.
- rx_ready = 1 in IDLE, ACCUM, DISCARD; 0 in HOLD. Decoded from the registered state, with no combinational path from word_ready.
- Leading zeros count as digits: "00000000A" with DATA_WIDTH=32 is an overflow.

## Timing
- Reset (rst_n low at a clock edge): state IDLE, rx_ready = 1 from the first cycle after reset, word_out = 0, word_valid = 0, digit_count = 0, err_invalid = 0, err_overflow = 0, acc and count = 0.
- Reset mid-token or in HOLD discards everything; the pending word is lost.
- Terminator accepted at edge N -> word_valid = 1 after edge N. Output handshake at edge M -> word_valid = 0 and rx_ready = 1 after edge M. Next character is accepted from edge M+1.
- Error pulses are high for exactly the cycle after the edge that accepted the offending character.
- Throughput: one character per cycle while not in HOLD. The minimum token cost is digits + 1 terminator + 1 handshake cycle.
- word_ready asserted while word_valid = 0 has no effect.

## Test plan
- Reset, then "1A2b\r" one byte per cycle with word_ready = 1 -> single word 0x00001A2B, digit_count = 4, word_valid high 1 cycle, no errors.
- "DEADBEEF\n" with word_ready held low 5 cycles -> word_valid and word_out = 0xDEADBEEF stable, rx_ready = 0 throughout; rx_valid bytes offered during HOLD are not consumed. Release -> rx_ready = 1 next cycle.
- "\r\n  \r\n" -> no word_valid, no errors. "7\r\n" -> exactly one word 0x7 with digit_count = 1.
- "12G4 55\r" -> err_invalid pulse 1 cycle after 'G'. Then exactly one word 0x55; "12G4" emits nothing.
- "123456789 A\r" (DATA_WIDTH=32) -> err_overflow pulse after the 9th digit. Then word 0xA; full 8 digits "FFFFFFFF\r" -> 0xFFFFFFFF with no overflow.
- rst_n low for 1 cycle after "AB" mid-token, then "C\r" -> only word 0xC; also reset during HOLD -> word_valid = 0 the next cycle and rx_ready = 1.
